// File: rtl/tc0260dar_pkg.sv
// Shared types and colour helpers for the TC0260DAR palette/DAC block.
package tc0260dar_pkg;

   typedef enum logic {
      FMT_RGB444 = 1'b0,
      FMT_RGB555 = 1'b1
   } pal_fmt_e;

   typedef logic [1:0] cpu_state_e;

   localparam logic [1:0] CPU_IDLE    = 2'd0;
   localparam logic [1:0] CPU_RD_ADDR = 2'd1;
   localparam logic [1:0] CPU_RD_DATA = 2'd2;
   localparam logic [1:0] CPU_ACK     = 2'd3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic logic [7:0] expand4(input logic [3:0] n);
      return {n, n};
   endfunction

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   // (c * (fade + 1)) >> 8, so fade = 8'hFF leaves the channel untouched.
   function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [7:0] f);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, f} + 16'd1);
      return 8'(p >> 8);
   endfunction

endpackage

// File: rtl/tc0260dar_if.sv
// CPU-side palette bus between the 68000 glue and the palette block.
// Handshake: the master holds cs and the address/control/data stable until
// cpu_dtack_n goes low; read data on cpu_dout is valid while cpu_dtack_n is low.
interface tc0260dar_if #(
   parameter int IDX_W = 12
) ();
   logic             cs;
   logic [IDX_W-1:0] cpu_addr;
   logic             cpu_rw;
   logic [1:0]       cpu_ds_n;
   logic [15:0]      cpu_din;
   logic [15:0]      cpu_dout;
   logic             cpu_dtack_n;

   modport master (
      output cs, cpu_addr, cpu_rw, cpu_ds_n, cpu_din,
      input  cpu_dout, cpu_dtack_n
   );

   modport slave (
      input  cs, cpu_addr, cpu_rw, cpu_ds_n, cpu_din,
      output cpu_dout, cpu_dtack_n
   );
endinterface

// File: rtl/tc0260dar_ram.sv
// True dual-port palette RAM, read-first on both ports, byte enables on port A.
module tc0260dar_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] a_addr,
   input  logic [1:0]    a_we,
   input  logic [15:0]   a_din,
   output logic [15:0]   a_dout,
   input  logic          b_en,
   input  logic [AW-1:0] b_addr,
   output logic [15:0]   b_dout
);

   logic [15:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      a_dout <= mem[a_addr];
      if (a_we[1]) mem[a_addr][15:8] <= a_din[15:8];
      if (a_we[0]) mem[a_addr][7:0]  <= a_din[7:0];
   end

   // Non-blocking read sees the pre-write word on a same-address collision.
   always_ff @(posedge clk) begin
      if (b_en) b_dout <= mem[b_addr];
   end

endmodule

// File: rtl/tc0260dar_palette.sv
// Palette lookup + RGB expansion after the priority mixer, with 68000 palette access.
// Optional output fade register: define TC0260DAR_FADE_EN.
module tc0260dar_palette
   import tc0260dar_pkg::*;
#(
   parameter int IDX_W    = 12,
   parameter bit ACK_HOLD = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pixel,
   input  logic [13:0] color_in,
   input  logic        hblank_in,
   input  logic        vblank_in,
   input  logic        pal_fmt,
   tc0260dar_if.slave  cpu,
`ifdef TC0260DAR_FADE_EN
   input  logic        fade_we,
   input  logic [7:0]  fade_din,
`endif
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hblank_out,
   output logic        vblank_out,
   output cpu_state_e  cpu_state_o
);

   cpu_state_e  state_q, state_d;
   logic        pend_q, pend_d;
   logic [15:0] cpu_dout_q, cpu_dout_d;
   logic [1:0]  ram_we;
   logic [15:0] ram_a_dout;
   logic [15:0] pix_word;
   logic        hb1_q, vb1_q;
   logic        hb2_q, vb2_q;
   rgb_t        conv, shaded, rgb_q;
   logic        unused_bits;

   assign unused_bits = ^{color_in[13:IDX_W], pix_word[0]};

   // pend_q blocks a new access until cs is released after a pulsed DTACK.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      cpu_dout_d = cpu_dout_q;
      ram_we     = 2'b00;
      if (pend_q && !cpu.cs) pend_d = 1'b0;
      case (state_q)
         CPU_IDLE: begin
            if (cpu.cs && !pend_q) begin
               if (cpu.cpu_rw) begin
                  state_d = CPU_RD_ADDR;
               end else begin
                  ram_we  = ~cpu.cpu_ds_n;
                  state_d = CPU_ACK;
               end
            end
         end
         CPU_RD_ADDR: state_d = CPU_RD_DATA;
         CPU_RD_DATA: begin
            cpu_dout_d = ram_a_dout;
            state_d    = CPU_ACK;
         end
         CPU_ACK: begin
            if (!ACK_HOLD) begin
               state_d = CPU_IDLE;
               pend_d  = cpu.cs;
            end else if (!cpu.cs) begin
               state_d = CPU_IDLE;
            end
         end
         default: state_d = CPU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CPU_IDLE;
         pend_q     <= 1'b0;
         cpu_dout_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

   assign cpu.cpu_dout    = cpu_dout_q;
   assign cpu.cpu_dtack_n = (state_q != CPU_ACK);
   assign cpu_state_o     = state_q;

   // The RAM's pixel-side address register is the P0 index stage; its data
   // register, together with hb1/vb1, forms P1.
   tc0260dar_ram #(.AW(IDX_W)) u_ram (
      .clk    (clk),
      .a_addr (cpu.cpu_addr),
      .a_we   (ram_we & {2{~reset}}),
      .a_din  (cpu.cpu_din),
      .a_dout (ram_a_dout),
      .b_en   (ce_pixel),
      .b_addr (color_in[IDX_W-1:0]),
      .b_dout (pix_word)
   );

   always_comb begin
      conv = '0;
      if (pal_fmt_e'(pal_fmt) == FMT_RGB555) begin
         conv.r = expand5({pix_word[15:12], pix_word[3]});
         conv.g = expand5({pix_word[11:8],  pix_word[2]});
         conv.b = expand5({pix_word[7:4],   pix_word[1]});
      end else begin
         conv.r = expand4(pix_word[11:8]);
         conv.g = expand4(pix_word[7:4]);
         conv.b = expand4(pix_word[3:0]);
      end
   end

`ifdef TC0260DAR_FADE_EN
   logic [7:0] fade_q;

   always_ff @(posedge clk) begin
      if (reset)        fade_q <= 8'hFF;
      else if (fade_we) fade_q <= fade_din;
   end

   assign shaded = '{r: fade_scale(conv.r, fade_q),
                     g: fade_scale(conv.g, fade_q),
                     b: fade_scale(conv.b, fade_q)};
`else
   assign shaded = conv;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         hb1_q <= 1'b1;
         vb1_q <= 1'b1;
         hb2_q <= 1'b1;
         vb2_q <= 1'b1;
         rgb_q <= '0;
      end else if (ce_pixel) begin
         hb1_q <= hblank_in;
         vb1_q <= vblank_in;
         hb2_q <= hb1_q;
         vb2_q <= vb1_q;
         rgb_q <= (hb1_q || vb1_q) ? '0 : shaded;
      end
   end

   assign red        = rgb_q.r;
   assign green      = rgb_q.g;
   assign blue       = rgb_q.b;
   assign hblank_out = hb2_q;
   assign vblank_out = vb2_q;

endmodule
